// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: reset PC, FSM state codes, PC arithmetic.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fetch_sequencer_pkg;

  // Default first fetch address after reset (word aligned)
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_STALL = 2'd3;

  // Sequential fetch stride and ARM pipeline read-ahead (PC reads as instr + 8)
  localparam logic [31:0] PC_INC      = 32'd4;
  localparam logic [31:0] PIPE_OFFSET = 32'd8;

endpackage

// File: rtl/fetch_sequencer_branch_offset_align.sv
// Turns a signed 24-bit B/BL word offset into a sign-extended 32-bit byte offset.
// Latency: purely combinational.
// Backpressure: none.
module branch_offset_align (
  input  logic [23:0] imm24_i,
  output logic [31:0] offset_o
);

  // Sign-extend to 30 bits, then shift left by two to convert words to bytes
  assign offset_o = {{6{imm24_i[23]}}, imm24_i, 2'b00};

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues req/ack fetches, redirects on taken branches.
// Latency: instr_valid 1 cycle after imem_ack; branch target requested next cycle (or after drain ack).
// Backpressure: stall blocks new requests but never withdraws an outstanding req. Optional FETCH_LINK_EN adds link-register write.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [23:0]       br_imm24,
  input  logic              stall
`ifdef FETCH_LINK_EN
  ,
  input  logic              br_link,
  output logic              lr_we,
  output logic [ADDR_W-1:0] lr_data
`endif
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              ivld_q, ivld_d;

  logic [31:0]       br_offset;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] seq_addr;
  logic [1:0]        after_ack;

  branch_offset_align u_align (
    .imm24_i  (br_imm24),
    .offset_o (br_offset)
  );

  // Branch target and sequential successor; both wrap silently modulo 2^32
  assign tgt       = br_pc + PIPE_OFFSET + br_offset;
  assign seq_addr  = addr_q + PC_INC;
  assign after_ack = stall ? ST_STALL : ST_FETCH;

  // Request is held in FETCH and DRAIN so it is never withdrawn mid-handshake
  assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem_addr   = addr_q;
  assign instr_valid = ivld_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;

  // Next-state logic: PC sequencing, branch redirect, wrong-path drain, stall
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ivld_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = stall ? ST_STALL : ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          if (!br_valid) begin
            instr_d = imem_rdata;
            ipc_d   = addr_q;
            ivld_d  = 1'b1;
            addr_d  = seq_addr;
          end else begin
            // Word just returned is wrong-path; drop it and redirect
            addr_d = tgt;
          end
          state_d = after_ack;
        end else if (br_valid) begin
          // Outstanding request must complete first; remember where to go
          pend_d  = tgt;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (br_valid) begin
          pend_d = tgt;
        end
        if (imem_ack) begin
          addr_d  = br_valid ? tgt : pend_q;
          state_d = after_ack;
        end
      end
      ST_STALL: begin
        if (br_valid) begin
          addr_d = tgt;
        end
        if (!stall) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops req immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= RESET_PC;
      pend_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      ivld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ivld_q  <= ivld_d;
    end
  end

`ifdef FETCH_LINK_EN
  logic              lr_we_q;
  logic [ADDR_W-1:0] lr_data_q;

  assign lr_we   = lr_we_q;
  assign lr_data = lr_data_q;

  // Link register write: one-cycle pulse with return address for each accepted BL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_we_q   <= 1'b0;
      lr_data_q <= '0;
    end else begin
      lr_we_q <= br_valid && br_link && (state_q != ST_IDLE);
      if (br_valid && br_link && (state_q != ST_IDLE)) begin
        lr_data_q <= br_pc + PC_INC;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a scoreboard monitor.
// Stimulus pushes expected fetch addresses / instructions; monitor pops on each handshake and instr_valid.
// Memory returns ~address as the instruction word.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        br_valid;
  logic [31:0] br_pc;
  logic [23:0] br_imm24;
  logic        stall;
`ifdef FETCH_LINK_EN
  logic        br_link;
  logic        lr_we;
  logic [31:0] lr_data;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] req_q[$];
  logic [63:0] ins_q[$];

  fetch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .br_valid    (br_valid),
    .br_pc       (br_pc),
    .br_imm24    (br_imm24),
    .stall       (stall)
`ifdef FETCH_LINK_EN
    ,
    .br_link     (br_link),
    .lr_we       (lr_we),
    .lr_data     (lr_data)
`endif
  );

  assign imem_rdata = ~imem_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Acked fetch that must be delivered as an instruction
  task automatic exp_fetch(input logic [31:0] a);
    req_q.push_back(a);
    ins_q.push_back({a, ~a});
  endtask

  // Acked fetch that must be discarded
  task automatic exp_flush(input logic [31:0] a);
    req_q.push_back(a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold ack high until n handshakes have happened (bounded)
  task automatic acks(input int n);
    int got = 0;
    int cyc = 0;
    imem_ack = 1'b1;
    while (got < n && cyc < 50) begin
      @(negedge clk);
      if (imem_req) got++;
      cyc++;
    end
    if (got < n) begin
      n_vec++;
      n_fail++;
      $display("FAIL ack_timeout: got %0d handshakes expected %0d", got, n);
    end
    step();
    imem_ack = 1'b0;
  endtask

  // Scoreboard monitor: compares every handshake and every delivered instruction
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_ack) begin
        if (req_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_ack: addr %h with empty expectation queue", imem_addr);
        end else begin
          chk("ack_addr", imem_addr, req_q.pop_front());
        end
      end
      if (instr_valid) begin
        if (ins_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_instr: pc %h instr %h", instr_pc, instr);
        end else begin
          logic [63:0] e;
          e = ins_q.pop_front();
          chk("instr_pc", instr_pc, e[63:32]);
          chk("instr", instr, e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    br_valid = 1'b0;
    br_pc    = '0;
    br_imm24 = '0;
    stall    = 1'b0;
`ifdef FETCH_LINK_EN
    br_link  = 1'b0;
`endif
    #7;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_LINK_EN
    chk("rst_lr_we", {31'd0, lr_we}, 32'd0);
    chk("rst_lr_data", lr_data, 32'h0);
`endif

    // Sequential fetch, ack every cycle
    step();
    rst_n = 1'b1;
    exp_fetch(32'h0);
    exp_fetch(32'h4);
    exp_fetch(32'h8);
    exp_fetch(32'hC);
    acks(4);
    chk("seq_next_addr", imem_addr, 32'h10);

    // Branch with coincident ack: 0x100 + 8 + 0x40 = 0x148
    exp_flush(32'h10);
    br_valid = 1'b1;
    br_pc    = 32'h100;
    br_imm24 = 24'h000010;
    imem_ack = 1'b1;
    step();
    br_valid = 1'b0;
    imem_ack = 1'b0;
    chk("br_ack_addr", imem_addr, 32'h148);
    chk("br_ack_req", {31'd0, imem_req}, 32'd1);
`ifdef FETCH_LINK_EN
    chk("nolink_lr_we", {31'd0, lr_we}, 32'd0);
`endif
    exp_fetch(32'h148);
    acks(1);

    // Branch without ack: drain stale 0x14C, then 0x20 + 8 - 8 = 0x20
    br_valid = 1'b1;
    br_pc    = 32'h20;
    br_imm24 = 24'hFFFFFE;
    step();
    br_valid = 1'b0;
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'h14C);
    step();
    chk("drain_addr2", imem_addr, 32'h14C);
    step();
    exp_flush(32'h14C);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("drain_tgt", imem_addr, 32'h20);
    chk("drain_tgt_req", {31'd0, imem_req}, 32'd1);
    exp_fetch(32'h20);
    acks(1);

    // Stall during an outstanding fetch
    stall = 1'b1;
    step();
    chk("stall_hold_req", {31'd0, imem_req}, 32'd1);
    chk("stall_hold_addr", imem_addr, 32'h24);
    exp_fetch(32'h24);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("stalled_req", {31'd0, imem_req}, 32'd0);
    chk("stalled_addr", imem_addr, 32'h28);
    step();
    chk("stalled_req2", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    step();
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h28);
    exp_fetch(32'h28);
    acks(1);

    // Branch (BL in link build) while stalled: 0x40 + 8 + 0x1C4 = 0x20C
    stall = 1'b1;
    exp_fetch(32'h2C);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    br_valid = 1'b1;
    br_pc    = 32'h40;
    br_imm24 = 24'h000071;
`ifdef FETCH_LINK_EN
    br_link  = 1'b1;
`endif
    step();
    br_valid = 1'b0;
`ifdef FETCH_LINK_EN
    br_link  = 1'b0;
    chk("bl_lr_we", {31'd0, lr_we}, 32'd1);
    chk("bl_lr_data", lr_data, 32'h44);
`endif
    chk("stall_br_addr", imem_addr, 32'h20C);
    chk("stall_br_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    step();
`ifdef FETCH_LINK_EN
    chk("bl_lr_we_pulse", {31'd0, lr_we}, 32'd0);
`endif
    chk("stall_br_resume", imem_addr, 32'h20C);
    exp_fetch(32'h20C);
    acks(1);

    // Address wrap: branch to 0xFFFFFFFC, next sequential is 0
    exp_flush(32'h210);
    br_valid = 1'b1;
    br_pc    = 32'hFFFF_FFF4;
    br_imm24 = 24'h000000;
    imem_ack = 1'b1;
    step();
    br_valid = 1'b0;
    imem_ack = 1'b0;
    chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
    exp_fetch(32'hFFFF_FFFC);
    acks(1);
    chk("wrap_seq", imem_addr, 32'h0);
    exp_fetch(32'h0);
    acks(1);
    step();

    // Asynchronous reset mid-request
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    chk("pre_rst_addr", imem_addr, 32'h4);
    rst_n = 1'b0;
    #2;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_addr", imem_addr, 32'h0);
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    exp_fetch(32'h0);
    exp_fetch(32'h4);
    acks(2);
    step();
    step();

    chk("req_q_drained", req_q.size(), 32'd0);
    chk("ins_q_drained", ins_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
